// File: rtl/int_ctrl_if.sv
// Register bus between a CPU-side master and the interrupt controller.
// The slave returns registered read data one clock after the address is presented.
interface int_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/int_ctrl.sv
// Interrupt controller: per-channel edge/level latching, mask, force, W1C, priority readout.
// Latency: irq_in edge -> pending next clock -> irq the clock after; reads 1 clock; no backpressure.
module int_ctrl #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    int_ctrl_if.slave          bus,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq
);

    localparam logic [2:0] A_PEND  = 3'd0;
    localparam logic [2:0] A_MASK  = 3'd1;
    localparam logic [2:0] A_MODE  = 3'd2;
    localparam logic [2:0] A_FORCE = 3'd3;
    localparam logic [2:0] A_ACT   = 3'd4;
    localparam logic [2:0] A_CTRL  = 3'd5;

    logic [NUM_IRQ-1:0] pending, mask, mode, irq_d;
    logic [NUM_IRQ-1:0] edge_det, set_vec, clr_vec, pending_nxt, active, wd_lo;
    logic               ctrl_en;
    logic               wr_en;
    logic [3:0]         prio_idx;
    logic [15:0]        active_word;
    logic [15:0]        rd_nxt;
    logic               unused_wd;

    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign wd_lo     = bus.writedata[NUM_IRQ-1:0];
    assign unused_wd = ^bus.writedata;

    assign edge_det = irq_in & ~irq_d;
    assign set_vec  = (mode & edge_det) | (~mode & irq_in)
                    | ({NUM_IRQ{wr_en && (bus.address == A_FORCE)}} & wd_lo);
    assign clr_vec  = {NUM_IRQ{wr_en && (bus.address == A_PEND)}} & wd_lo;
    // Set is OR-ed in after the clear so a same-cycle set always wins.
    assign pending_nxt = (pending & ~clr_vec) | set_vec;
    assign active      = pending & mask;

    always_comb begin
        prio_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) prio_idx = 4'(i);
        end
    end

    assign active_word = {(|active), 11'b0, prio_idx};

    always_comb begin
        rd_nxt = '0;
        case (bus.address)
            A_PEND:  rd_nxt = 16'(pending);
            A_MASK:  rd_nxt = 16'(mask);
            A_MODE:  rd_nxt = 16'(mode);
            A_ACT:   rd_nxt = active_word;
            A_CTRL:  rd_nxt = {15'b0, ctrl_en};
            default: rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending      <= '0;
            mask         <= '0;
            mode         <= '0;
            irq_d        <= '0;
            ctrl_en      <= 1'b0;
            irq          <= 1'b0;
            bus.readdata <= '0;
        end else begin
            pending      <= pending_nxt;
            irq_d        <= irq_in;
            irq          <= ctrl_en & (|active);
            bus.readdata <= rd_nxt;
            if (wr_en && (bus.address == A_MASK)) mask    <= wd_lo;
            if (wr_en && (bus.address == A_MODE)) mode    <= wd_lo;
            if (wr_en && (bus.address == A_CTRL)) ctrl_en <= bus.writedata[0];
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed vector table, reset sequences, then random traffic vs a reference model.
module tb_int_ctrl;
    localparam int NI = 8;
    localparam logic [15:0] LIM = 16'((1 << NI) - 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [NI-1:0] irq_in = '0;
    logic          irq;
    int            n_chk = 0;
    int            n_fail = 0;
    bit            model_on = 1'b0;

    int_ctrl_if bus ();

    int_ctrl #(.NUM_IRQ(NI)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .irq_in  (irq_in),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: register contents as plain 16-bit words, updated per-channel by the rules.
    logic [15:0] m_pend, m_mask, m_mode, m_prev, m_rd;
    logic        m_ctrl, m_irq;

    function automatic logic [15:0] m_active_word();
        logic [15:0] act = m_pend & m_mask;
        int k = 0;
        if (act == 0) return 16'h0000;
        while (!act[k]) k++;
        return 16'h8000 | 16'(k);
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return m_pend;
            3'd1:    return m_mask;
            3'd2:    return m_mode;
            3'd4:    return m_active_word();
            3'd5:    return {15'b0, m_ctrl};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] m_next_pend(input bit wr, input logic [2:0] a,
                                                input logic [15:0] wd, input logic [15:0] inp);
        logic [15:0] np = m_pend;
        for (int i = 0; i < NI; i++) begin
            bit s = m_mode[i] ? (inp[i] && !m_prev[i]) : inp[i];
            if (wr && a == 3'd3 && wd[i]) s = 1'b1;
            if (s) np[i] = 1'b1;
            else if (wr && a == 3'd0 && wd[i]) np[i] = 1'b0;
        end
        return np;
    endfunction

    wire m_wr = bus.chipselect && !bus.write_n;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pend <= 0; m_mask <= 0; m_mode <= 0; m_prev <= 0;
            m_ctrl <= 0; m_irq <= 0; m_rd <= 0;
        end else begin
            m_rd   <= m_read(bus.address);
            m_irq  <= m_ctrl && ((m_pend & m_mask) != 0);
            m_pend <= m_next_pend(m_wr, bus.address, bus.writedata, 16'(irq_in));
            m_prev <= 16'(irq_in);
            if (m_wr && bus.address == 3'd1) m_mask <= bus.writedata & LIM;
            if (m_wr && bus.address == 3'd2) m_mode <= bus.writedata & LIM;
            if (m_wr && bus.address == 3'd5) m_ctrl <= bus.writedata[0];
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("model readdata", bus.readdata, m_rd);
            chk("model irq", {15'b0, irq}, {15'b0, m_irq});
        end
    end

    typedef struct {
        logic [2:0]  a;
        bit          wr;
        logic [15:0] wd;
        logic [7:0]  in;
        logic [15:0] rd;
        bit          irq;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [2:0] a, input bit wr, input logic [15:0] wd,
                                input logic [7:0] in, input logic [15:0] rd, input bit iq);
        vec_t v;
        v.a = a; v.wr = wr; v.wd = wd; v.in = in; v.rd = rd; v.irq = iq;
        return v;
    endfunction

    task automatic drive(input logic [2:0] a, input bit wr, input logic [15:0] wd, input logic [7:0] in);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = !wr;
        bus.writedata  = wd;
        irq_in         = in;
    endtask

    task automatic apply(input string nm, input vec_t v);
        drive(v.a, v.wr, v.wd, v.in);
        @(negedge clk);
        chk({nm, " rd"}, bus.readdata, v.rd);
        chk({nm, " irq"}, {15'b0, irq}, {15'b0, v.irq});
    endtask

    initial begin
        bus.address = 0; bus.chipselect = 0; bus.write_n = 1; bus.writedata = 0;
        // edge latency and W1C
        tbl.push_back(mk(2, 1, 16'h0001, 8'h00, 16'h0000, 0));
        tbl.push_back(mk(1, 1, 16'h0001, 8'h00, 16'h0000, 0));
        tbl.push_back(mk(5, 1, 16'h0001, 8'h00, 16'h0000, 0));
        tbl.push_back(mk(2, 0, 16'h0000, 8'h01, 16'h0001, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 8'h00, 16'h0001, 1));
        tbl.push_back(mk(0, 1, 16'h0001, 8'h00, 16'h0001, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 8'h00, 16'h0000, 0));
        // level persistence
        tbl.push_back(mk(2, 1, 16'h0000, 8'h00, 16'h0001, 0));
        tbl.push_back(mk(1, 1, 16'h0004, 8'h00, 16'h0001, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 8'h04, 16'h0000, 0));
        tbl.push_back(mk(0, 1, 16'h0004, 8'h04, 16'h0004, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 8'h04, 16'h0004, 1));
        tbl.push_back(mk(0, 1, 16'h0004, 8'h00, 16'h0004, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 8'h00, 16'h0000, 0));
        // priority readout
        tbl.push_back(mk(3, 1, 16'h00A0, 8'h00, 16'h0000, 0));
        tbl.push_back(mk(1, 1, 16'h00FF, 8'h00, 16'h0004, 0));
        tbl.push_back(mk(4, 0, 16'h0000, 8'h00, 16'h8005, 1));
        tbl.push_back(mk(1, 1, 16'h0080, 8'h00, 16'h00FF, 1));
        tbl.push_back(mk(4, 0, 16'h0000, 8'h00, 16'h8007, 1));
        tbl.push_back(mk(1, 1, 16'h0000, 8'h00, 16'h0080, 1));
        tbl.push_back(mk(4, 0, 16'h0000, 8'h00, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 8'h00, 16'h00A0, 0));
        // set/clear collision
        tbl.push_back(mk(0, 1, 16'h00A0, 8'h00, 16'h00A0, 0));
        tbl.push_back(mk(2, 1, 16'h00FF, 8'h00, 16'h0000, 0));
        tbl.push_back(mk(0, 1, 16'h0008, 8'h08, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 8'h00, 16'h0008, 0));
        // global enable gate
        tbl.push_back(mk(5, 1, 16'h0000, 8'h00, 16'h0001, 0));
        tbl.push_back(mk(1, 1, 16'h0008, 8'h00, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 8'h00, 16'h0008, 0));
        tbl.push_back(mk(5, 1, 16'h0001, 8'h00, 16'h0000, 0));
        tbl.push_back(mk(5, 0, 16'h0000, 8'h00, 16'h0001, 1));
        // address map
        tbl.push_back(mk(3, 0, 16'h0000, 8'h00, 16'h0000, 1));
        tbl.push_back(mk(6, 0, 16'h0000, 8'h00, 16'h0000, 1));
        tbl.push_back(mk(7, 0, 16'h0000, 8'h00, 16'h0000, 1));
        tbl.push_back(mk(6, 1, 16'hFFFF, 8'h00, 16'h0000, 1));
        tbl.push_back(mk(1, 1, 16'hFFFF, 8'h00, 16'h0008, 1));
        tbl.push_back(mk(1, 0, 16'h0000, 8'h00, 16'h00FF, 1));
        tbl.push_back(mk(5, 1, 16'hFFFF, 8'h00, 16'h0001, 1));
        tbl.push_back(mk(5, 0, 16'h0000, 8'h00, 16'h0001, 1));

        #1 reset_n = 1'b0;
        #1;
        chk("reset readdata", bus.readdata, 16'h0000);
        chk("reset irq", {15'b0, irq}, 16'h0000);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        model_on = 1'b1;

        for (int k = 0; k < tbl.size(); k++) apply($sformatf("vec%0d", k), tbl[k]);

        // reset mid-operation with irq asserted
        #2 reset_n = 1'b0;
        #1;
        chk("midreset irq", {15'b0, irq}, 16'h0000);
        chk("midreset readdata", bus.readdata, 16'h0000);
        @(negedge clk);
        #2 reset_n = 1'b1;
        apply("post-reset pending", mk(0, 0, 16'h0000, 8'h00, 16'h0000, 0));
        apply("post-reset mask", mk(1, 0, 16'h0000, 8'h00, 16'h0000, 0));
        apply("post-reset ctrl", mk(5, 0, 16'h0000, 8'h00, 16'h0000, 0));

        // random traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            bus.address    = 3'($urandom_range(0, 7));
            bus.chipselect = ($urandom_range(0, 3) != 0);
            bus.write_n    = 1'($urandom_range(0, 1));
            bus.writedata  = 16'($urandom);
            if (bus.address == 3'd5 && $urandom_range(0, 3) != 0) bus.writedata[0] = 1'b1;
            irq_in         = 8'($urandom & $urandom);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of interrupt inputs (legal 1..16).
REQ-002 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port address, input, 3, register select.
REQ-005 SHALL have port chipselect, input, 1, slave select.
REQ-006 SHALL have port write_n, input, 1, active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-007 SHALL have port writedata, input, 16, write data.
REQ-008 SHALL have port readdata, output, 16, registered read data.
REQ-009 SHALL have port irq_in, input, NUM_IRQ, interrupt requests from peripherals (e.g. timer irq), synchronous to clk.
REQ-010 SHALL have port irq, output, 1, combined interrupt request to the CPU.

Function
REQ-011 SHALL decode address: 0 PENDING (R, write-1-to-clear), 1 MASK (RW), 2 MODE (RW; 1=edge, 0=level), 3 FORCE (W; reads 0), 4 ACTIVE (R), 5 CONTROL (RW; bit0 global enable, other bits read 0); 6, 7 read 0, writes ignored.
REQ-012 SHALL keep irq_d, a one-cycle delayed copy of irq_in; edge[i] = irq_in[i] & ~irq_d[i].
REQ-013 SHALL set pending[i] on the clock after edge[i]=1 when MODE[i]=1.
REQ-014 SHALL set pending[i] on every clock where irq_in[i]=1 when MODE[i]=0.
REQ-015 SHALL set pending[i] when FORCE is written with writedata[i]=1.
REQ-016 SHALL clear pending[i] when PENDING is written with writedata[i]=1, unless a set condition (REQ-013..015) for bit i occurs in the same cycle, in which case set wins.
REQ-017 Result: a level channel whose input is still high stays pending after W1C.
REQ-018 SHALL latch pending regardless of MASK; MASK only gates irq and ACTIVE.
REQ-019 SHALL compute the active vector as pending & MASK.
REQ-020 SHALL register irq = CONTROL[0] & (|active), one clock after the state that causes it.
REQ-021 irq_in edge at clock t SHALL give pending at t+1 and irq at t+2.
REQ-022 SHALL return in ACTIVE bit15 = |active, bits3:0 = index of the lowest-numbered set bit of active (lowest index = highest priority), all other bits 0; bits3:0 = 0 when bit15 = 0.
REQ-023 SHALL register readdata from the addressed register on every clock regardless of chipselect (1-cycle read latency); register bits at and above NUM_IRQ read 0.
REQ-024 SHALL give a read of PENDING in the same cycle as a write to it the pre-write value.
REQ-025 SHALL take effect on the next clock for MASK, MODE or CONTROL writes; bits at and above NUM_IRQ are not stored.
REQ-026 SHALL cause no pending change from a MODE change alone; the next evaluation uses the new mode.

Reset
REQ-027 While reset_n=0, SHALL force asynchronously: readdata=0, irq=0, pending=0, MASK=0, MODE=0 (all level), CONTROL=0, irq_d=0.
REQ-028 SHALL treat an irq_in bit that is high at reset release as an edge on the first clock (irq_d=0).
REQ-029 Reset asserted mid-operation SHALL discard all pending state; no interrupt survives reset.

Verification
REQ-030 Edge latency: MODE=0x01, MASK=0x01, CONTROL=1, pulse irq_in[0] high for 1 cycle at t -> PENDING=0x0001 from t+1, irq=1 from t+2; write PENDING=0x0001 -> irq=0 two clocks later.
REQ-031 Level persistence: MODE=0, MASK=0x04, CONTROL=1, hold irq_in[2]=1, write PENDING=0x0004 -> PENDING still reads 0x0004, irq stays 1; drop irq_in[2], write W1C again -> PENDING=0, irq=0.
REQ-032 Priority: FORCE=0x00A0, MASK=0x00FF -> ACTIVE reads 0x8005; MASK=0x0080 -> ACTIVE reads 0x8007; MASK=0 -> ACTIVE=0x0000, PENDING still 0x00A0.
REQ-033 Set/clear collision: MODE=0xFF, edge on irq_in[3] in the same cycle as W1C of PENDING bit 3 -> PENDING bit 3 = 1 afterwards.
REQ-034 Global gate and reset: pending&MASK nonzero, CONTROL=0 -> irq=0; CONTROL=1 -> irq=1 next clock; assert reset_n mid-operation -> irq, readdata, PENDING, MASK all 0 immediately.
REQ-035 Address map: read addresses 3, 6, 7 -> 0x0000; write 0xFFFF to MASK with NUM_IRQ=8 -> MASK reads 0x00FF.
